// File: rtl/display_pkg.sv
// Shared definitions for the display path: converter FSM states and BCD sizing constants.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int BCD_DIGITS = 4;
   localparam int BCD_MAX    = 9999;
   localparam int DIGITS_W   = 16;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: a digit of 5 or more gets +3 so the next shift carries correctly.
module bcd_add3 (
   input  logic [3:0] nibble_in,
   output logic [3:0] nibble_out
);

   assign nibble_out = (nibble_in >= 4'd5) ? nibble_in + 4'd3 : nibble_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), saturating at 9999, with a start/busy/done handshake.
module bin_to_bcd_seq
   import display_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [BIN_W-1:0]    bin,
   output logic                busy,
   output logic                done,
   output logic [DIGITS_W-1:0] digits,
   output logic                ovf
);

   localparam int CNT_W = $clog2(BIN_W + 1);

   state_t               state;
   logic [BIN_W-1:0]     bin_reg;
   logic [DIGITS_W-1:0]  scratch;
   logic [DIGITS_W-1:0]  corrected;
   logic [CNT_W-1:0]     iter_cnt;
   logic                 ovf_pend;
   logic                 over_range;

   // Constant-false when BIN_W is too narrow to exceed 9999.
   assign over_range = (32'(bin) > 32'(BCD_MAX));

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nibble_in  (scratch[4*g +: 4]),
         .nibble_out (corrected[4*g +: 4])
      );
   end

   // The scratch MSB is rotated into bin_reg's free LSB rather than dropped; it is always 0
   // because the value is saturated, and bin_reg's low bits are never read after shifting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bin_reg  <= '0;
         scratch  <= '0;
         iter_cnt <= '0;
         ovf_pend <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         digits   <= '0;
         ovf      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (over_range) begin
                     bin_reg  <= BIN_W'(BCD_MAX);
                     ovf_pend <= 1'b1;
                  end else begin
                     bin_reg  <= bin;
                     ovf_pend <= 1'b0;
                  end
                  scratch  <= '0;
                  iter_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               scratch  <= {corrected[DIGITS_W-2:0], bin_reg[BIN_W-1]};
               bin_reg  <= {bin_reg[BIN_W-2:0], corrected[DIGITS_W-1]};
               iter_cnt <= iter_cnt + CNT_W'(1);
               if (iter_cnt == CNT_W'(BIN_W - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               digits <= scratch;
               ovf    <= ovf_pend;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed table, handshake corner cases, random values vs. a decimal model.
module tb_bin_to_bcd_seq;

   localparam int BIN_W = 14;
   localparam int LAT   = BIN_W + 1;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [BIN_W-1:0] bin;
   logic             busy;
   logic             done;
   logic [15:0]      digits;
   logic             ovf;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [BIN_W-1:0] value;
      logic [15:0]      exp_digits;
      logic             exp_ovf;
   } vec_t;

   vec_t vecs[7];

   bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bin    (bin),
      .busy   (busy),
      .done   (done),
      .digits (digits),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: saturate, then take decimal digits arithmetically.
   function automatic logic [16:0] ref_model(input int v);
      int sat;
      logic [15:0] d;
      sat = (v > 9999) ? 9999 : v;
      d = {4'(sat / 1000), 4'((sat / 100) % 10), 4'((sat / 10) % 10), 4'(sat % 10)};
      return {(v > 9999), d};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic launch(input logic [BIN_W-1:0] value);
      bin   = value;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic applyStimulus(input logic [BIN_W-1:0] value, output int lat, output int busy_cnt);
      @(negedge clk);
      launch(value);
      wait_done(lat, busy_cnt);
   endtask

   initial begin
      int lat, busy_cnt, done_seen, done_cyc;
      logic [16:0] exp;
      logic [BIN_W-1:0] rv;

      vecs[0] = '{14'd1234,  16'h1234, 1'b0};
      vecs[1] = '{14'd0,     16'h0000, 1'b0};
      vecs[2] = '{14'd9999,  16'h9999, 1'b0};
      vecs[3] = '{14'd5,     16'h0005, 1'b0};
      vecs[4] = '{14'd12000, 16'h9999, 1'b1};
      vecs[5] = '{14'd16383, 16'h9999, 1'b1};
      vecs[6] = '{14'd42,    16'h0042, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      bin   = '0;
      #22;
      checkOutput("reset_busy",   32'(busy),   32'd0);
      checkOutput("reset_done",   32'(done),   32'd0);
      checkOutput("reset_digits", 32'(digits), 32'h0);
      checkOutput("reset_ovf",    32'(ovf),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].value, lat, busy_cnt);
         checkOutput($sformatf("vec%0d_digits", i), 32'(digits), 32'(vecs[i].exp_digits));
         checkOutput($sformatf("vec%0d_ovf", i),    32'(ovf),    32'(vecs[i].exp_ovf));
         checkOutput($sformatf("vec%0d_latency", i), 32'(lat),    32'(LAT));
         checkOutput($sformatf("vec%0d_busy", i),   32'(busy_cnt), 32'(LAT));
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d_done_drop", i), 32'(done), 32'd0);
      end

      // Start while busy is ignored; bin changes mid-conversion; digits hold 0042 until done.
      @(negedge clk);
      launch(14'd1234);
      done_seen = 0;
      done_cyc  = 0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk);
         #1;
         if (c == 3) begin
            start = 1'b1;
            bin   = 14'd5678;
         end else if (c == 4) begin
            start = 1'b0;
            bin   = 14'd7777;
         end
         if (done) begin
            done_seen++;
            done_cyc = c;
            checkOutput("ign_digits", 32'(digits), 32'h1234);
         end else if (done_seen == 0) begin
            checkOutput($sformatf("ign_hold_c%0d", c), 32'(digits), 32'h0042);
         end
      end
      checkOutput("ign_done_count", 32'(done_seen), 32'd1);
      checkOutput("ign_done_cycle", 32'(done_cyc),  32'(LAT));
      checkOutput("ign_busy_after", 32'(busy),      32'd0);
      checkOutput("ign_digits_end", 32'(digits),    32'h1234);

      // Back-to-back: start raised during the done cycle of the previous conversion.
      applyStimulus(14'd1111, lat, busy_cnt);
      checkOutput("b2b_first", 32'(digits), 32'h1111);
      launch(14'd4321);
      wait_done(lat, busy_cnt);
      checkOutput("b2b_latency", 32'(lat),    32'(LAT));
      checkOutput("b2b_digits",  32'(digits), 32'h4321);

      // Asynchronous reset at iteration 7.
      @(negedge clk);
      launch(14'd8765);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_digits", 32'(digits), 32'h0);
      checkOutput("arst_busy",   32'(busy),   32'd0);
      checkOutput("arst_done",   32'(done),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(14'd8765, lat, busy_cnt);
      checkOutput("arst_redo", 32'(digits), 32'h8765);

      // Random values against the decimal model.
      for (int i = 0; i < 30; i++) begin
         rv  = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
         exp = ref_model(int'(rv));
         applyStimulus(rv, lat, busy_cnt);
         checkOutput($sformatf("rnd%0d_%0d_digits", i, rv), 32'(digits), 32'(exp[15:0]));
         checkOutput($sformatf("rnd%0d_%0d_ovf", i, rv),    32'(ovf),    32'(exp[16]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
